// File: rtl/mix_columns_iter_if.sv
// rtl/mix_columns_iter_if.sv - state-in / state-out handshake bundle for mix_columns_iter
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_bypass, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_bypass, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - column-serial AES MixColumns with final-round bypass
module mix_columns_iter (
    input  logic              clk,
    input  logic              rst,
    mix_columns_iter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   col_q, col_d;
    logic [127:0] work_q, work_d;
    logic         bypass_q, bypass_d;
    logic         out_valid_q, out_valid_d;
    logic [7:0]   a [4];
    logic [7:0]   b [4];

    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // The one shared column multiplier, fed by the column selected by col_q.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            a[r] = work_q[127 - 32*r - 8*int'(col_q) -: 8];
        end
        b[0] = xtime(a[0]) ^ xtime(a[1]) ^ a[1] ^ a[2] ^ a[3];
        b[1] = a[0] ^ xtime(a[1]) ^ xtime(a[2]) ^ a[2] ^ a[3];
        b[2] = a[0] ^ a[1] ^ xtime(a[2]) ^ xtime(a[3]) ^ a[3];
        b[3] = xtime(a[0]) ^ a[0] ^ a[1] ^ a[2] ^ xtime(a[3]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_q       <= 2'd0;
            work_q      <= '0;
            bypass_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            work_q      <= work_d;
            bypass_q    <= bypass_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        work_d      = work_q;
        bypass_d    = bypass_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d   = bus.in_data;
                    bypass_d = bus.in_bypass;
                    col_d    = 2'd0;
                    state_d  = COMPUTE;
                end
            end
            COMPUTE: begin
                // Bypass still walks all four columns so latency matches mixed rounds.
                for (int r = 0; r < 4; r++) begin
                    work_d[127 - 32*r - 8*int'(col_q) -: 8] = bypass_q ? a[r] : b[r];
                end
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work_q;
endmodule
